// File: rtl/dla_noc_mc_packetizer.sv
// DLA-side multi-channel NoC packetizer: round-robin request arbitration, HEAD/BODY/TAIL
// flit serialisation into the tx FIFO, and per-channel outstanding tracking via grant returns.
module dla_noc_mc_packetizer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LABEL_W = 2,
  parameter int unsigned X_W     = 4,
  parameter int unsigned Y_W     = 4,
  parameter int unsigned L_W     = 3,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned SRC_X   = 0,
  parameter int unsigned SRC_Y   = 0
) (
  input  logic                         clk_dla,
  input  logic                         rst_dla,
  input  logic [NUM_CH-1:0]            ch_req_vld,
  output logic [NUM_CH-1:0]            ch_req_rdy,
  input  logic [NUM_CH*(X_W+Y_W+L_W)-1:0] ch_req_dest,
  input  logic [NUM_CH*LEN_W-1:0]      ch_req_len,
  input  logic [NUM_CH-1:0]            ch_data_vld,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  output logic [NUM_CH-1:0]            ch_data_rdy,
  input  logic                         tx_afull,
  output logic                         tx_wen,
  output logic [LABEL_W+DATA_W-1:0]    tx_wdata,
  input  logic                         grnt_rempty,
  output logic                         grnt_ren,
  input  logic [X_W+Y_W+1:0]           grnt_rdata,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [X_W-1:0]               grant_x,
  output logic [Y_W-1:0]               grant_y,
  output logic                         err_unexpected_grant,
  output logic                         busy
);

  localparam int unsigned DEST_W = X_W + Y_W + L_W;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned SRCF_W = X_W + Y_W + ID_W;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);

  localparam logic [LABEL_W-1:0] LBL_HEAD     = LABEL_W'(0);
  localparam logic [LABEL_W-1:0] LBL_BODY     = LABEL_W'(1);
  localparam logic [LABEL_W-1:0] LBL_TAIL     = LABEL_W'(2);
  localparam logic [LABEL_W-1:0] LBL_HEADTAIL = LABEL_W'(3);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_ch;
  logic [LEN_W-1:0]    cur_len;
  logic [LEN_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    out_cnt [NUM_CH];

  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   inc_vec;
  logic [NUM_CH-1:0]   dec_vec;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     win_idx;
  logic                win_found;
  logic                issue;
  logic                beat;
  logic [DEST_W-1:0]   sel_dest;
  logic [LEN_W-1:0]    sel_len;
  logic [DATA_W-1:0]   head_data;
  logic [DATA_W-1:0]   cur_data;

  logic                gnt_vld_d;
  logic [ID_W-1:0]     g_dla;
  logic [X_W-1:0]      g_x;
  logic [Y_W-1:0]      g_y;
  logic                g_in_range;
  logic                g_zero;
  logic                g_unexp;

  // Channel eligibility: requesting and below the outstanding limit
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_req_vld[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  // Round-robin search starting at rr_ptr (the channel after the last winner)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ID_W'((32'(rr_ptr) + 32'(k)) % NUM_CH);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign issue    = (state == S_IDLE) && !tx_afull && win_found;
  assign beat     = (state == S_BODY) && !tx_afull && ch_data_vld[cur_ch];
  assign sel_dest = ch_req_dest[32'(win_idx)*DEST_W +: DEST_W];
  assign sel_len  = ch_req_len[32'(win_idx)*LEN_W +: LEN_W];
  assign cur_data = ch_data[32'(cur_ch)*DATA_W +: DATA_W];

  // Head payload: destination in the low bits, then the source {x, y, channel}
  always_comb begin
    head_data                    = '0;
    head_data[DEST_W-1:0]        = sel_dest;
    head_data[DEST_W +: SRCF_W]  = {X_W'(SRC_X), Y_W'(SRC_Y), win_idx};
  end

  always_comb begin
    ch_req_rdy  = '0;
    ch_data_rdy = '0;
    if (issue) ch_req_rdy[win_idx] = 1'b1;
    if (beat)  ch_data_rdy[cur_ch] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  // Packet FSM and registered flit output
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      cur_ch   <= '0;
      cur_len  <= '0;
      beat_cnt <= '0;
      tx_wen   <= 1'b0;
      tx_wdata <= '0;
    end else begin
      tx_wen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            cur_ch   <= win_idx;
            cur_len  <= sel_len;
            beat_cnt <= LEN_W'(1);
            rr_ptr   <= ID_W'((32'(win_idx) + 32'd1) % NUM_CH);
            tx_wen   <= 1'b1;
            if (sel_len == '0) begin
              tx_wdata <= {LBL_HEADTAIL, head_data};
              state    <= S_IDLE;
            end else begin
              tx_wdata <= {LBL_HEAD, head_data};
              state    <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (beat) begin
            tx_wen <= 1'b1;
            if (beat_cnt == cur_len) begin
              tx_wdata <= {LBL_TAIL, cur_data};
              state    <= S_IDLE;
            end else begin
              tx_wdata <= {LBL_BODY, cur_data};
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Grant path: rdata is valid the cycle after ren, results registered one cycle later
  assign grnt_ren   = !grnt_rempty;
  assign g_dla      = grnt_rdata[ID_W-1:0];
  assign g_y        = grnt_rdata[ID_W +: Y_W];
  assign g_x        = grnt_rdata[ID_W+Y_W +: X_W];
  assign g_in_range = 32'(g_dla) < NUM_CH;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    g_zero  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc_vec[i] = issue && (win_idx == ID_W'(i));
      if (gnt_vld_d && (g_dla == ID_W'(i))) begin
        if (out_cnt[i] == '0) g_zero = 1'b1;
        else                  dec_vec[i] = 1'b1;
      end
    end
    g_unexp = gnt_vld_d && (!g_in_range || g_zero);
  end

  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      gnt_vld_d            <= 1'b0;
      ch_grant             <= '0;
      grant_x              <= '0;
      grant_y              <= '0;
      err_unexpected_grant <= 1'b0;
    end else begin
      gnt_vld_d <= grnt_ren;
      ch_grant  <= '0;
      if (gnt_vld_d && g_in_range) begin
        ch_grant[g_dla] <= 1'b1;
        grant_x         <= g_x;
        grant_y         <= g_y;
      end
      if (g_unexp) err_unexpected_grant <= 1'b1;
    end
  end

  // Outstanding counters: issue and grant on the same cycle cancel
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      for (int i = 0; i < NUM_CH; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        out_cnt[i] <= out_cnt[i] + CNT_W'(inc_vec[i]) - CNT_W'(dec_vec[i]);
      end
    end
  end

endmodule

// File: tb/tb_dla_noc_mc_packetizer.sv
// Randomised scoreboard bench for dla_noc_mc_packetizer with a packet-level reference model.
module tb_dla_noc_mc_packetizer;

  localparam int NCH = 4;
  localparam int MAXO = 4;

  logic          clk_dla = 1'b0;
  logic          rst_dla;
  logic [3:0]    ch_req_vld;
  logic [3:0]    ch_req_rdy;
  logic [43:0]   ch_req_dest;
  logic [31:0]   ch_req_len;
  logic [3:0]    ch_data_vld;
  logic [255:0]  ch_data;
  logic [3:0]    ch_data_rdy;
  logic          tx_afull;
  logic          tx_wen;
  logic [65:0]   tx_wdata;
  logic          grnt_rempty;
  logic          grnt_ren;
  logic [9:0]    grnt_rdata;
  logic [3:0]    ch_grant;
  logic [3:0]    grant_x;
  logic [3:0]    grant_y;
  logic          err_unexpected_grant;
  logic          busy;

  always #5 clk_dla = ~clk_dla;

  dla_noc_mc_packetizer dut (
    .clk_dla(clk_dla), .rst_dla(rst_dla),
    .ch_req_vld(ch_req_vld), .ch_req_rdy(ch_req_rdy),
    .ch_req_dest(ch_req_dest), .ch_req_len(ch_req_len),
    .ch_data_vld(ch_data_vld), .ch_data(ch_data), .ch_data_rdy(ch_data_rdy),
    .tx_afull(tx_afull), .tx_wen(tx_wen), .tx_wdata(tx_wdata),
    .grnt_rempty(grnt_rempty), .grnt_ren(grnt_ren), .grnt_rdata(grnt_rdata),
    .ch_grant(ch_grant), .grant_x(grant_x), .grant_y(grant_y),
    .err_unexpected_grant(err_unexpected_grant), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] oh;
    logic [3:0] x;
    logic [3:0] y;
  } gexp_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [65:0] txq [$];
  gexp_t       gq  [$];
  int          dut_heads [$];

  // Reference model state
  int   m_cnt [NCH];
  int   inflight [NCH];
  bit   m_busy;
  int   m_ch, m_len, m_beat, m_rr;
  bit   m_err;
  bit   g_stage_v;
  logic [9:0] g_stage;
  bit   last_ren;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s act=%h exp=%h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s act=missing exp=event", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      inflight[i] = 0;
    end
    m_busy = 0; m_ch = 0; m_len = 0; m_beat = 0; m_rr = 0; m_err = 0;
    g_stage_v = 0; g_stage = '0; last_ren = 0;
    txq.delete();
    gq.delete();
  endtask

  task automatic quiet();
    ch_req_vld  = '0;
    ch_data_vld = '0;
    tx_afull    = 1'b0;
    grnt_rempty = 1'b1;
  endtask

  task automatic send_grant(input int c, input logic [3:0] x, input logic [3:0] y);
    grnt_rempty = 1'b0;
    grnt_rdata  = {x, y, 2'(c)};
    inflight[c]++;
  endtask

  // One clock: compare handshakes against the model, then advance the model past the edge
  task automatic tick();
    int w, c, len;
    logic [3:0] exp_rr, exp_dr;
    logic [63:0] hd;
    logic [1:0] lbl;
    int dla;
    #1;
    chk("busy", 66'(busy), 66'(m_busy));
    chk("err_flag", 66'(err_unexpected_grant), 66'(m_err));
    exp_rr = '0; exp_dr = '0; w = -1;
    if (!m_busy && !tx_afull) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (w < 0 && ch_req_vld[c] && m_cnt[c] < MAXO) w = c;
      end
    end
    if (w >= 0) exp_rr[w] = 1'b1;
    if (m_busy && !tx_afull && ch_data_vld[m_ch]) exp_dr[m_ch] = 1'b1;
    chk("req_rdy", 66'(ch_req_rdy), 66'(exp_rr));
    chk("data_rdy", 66'(ch_data_rdy), 66'(exp_dr));
    chk("grnt_ren", 66'(grnt_ren), 66'(!grnt_rempty));
    if (g_stage_v) begin
      dla = int'(g_stage[1:0]);
      if (m_cnt[dla] == 0) m_err = 1;
      else m_cnt[dla]--;
      if (inflight[dla] > 0) inflight[dla]--;
      gq.push_back(gexp_t'{4'(1 << dla), g_stage[9:6], g_stage[5:2]});
    end
    g_stage_v = !grnt_rempty;
    g_stage   = grnt_rdata;
    last_ren  = !grnt_rempty;
    if (w >= 0) begin
      len = int'(ch_req_len[w*8 +: 8]);
      hd = '0;
      hd[10:0]  = ch_req_dest[w*11 +: 11];
      hd[20:11] = {4'd0, 4'd0, 2'(w)};
      lbl = (len == 0) ? 2'd3 : 2'd0;
      txq.push_back({lbl, hd});
      m_cnt[w]++;
      m_rr = (w + 1) % NCH;
      if (len > 0) begin
        m_busy = 1; m_ch = w; m_len = len; m_beat = 0;
      end
    end else if (exp_dr != '0) begin
      m_beat++;
      lbl = (m_beat == m_len) ? 2'd2 : 2'd1;
      txq.push_back({lbl, ch_data[m_ch*64 +: 64]});
      if (m_beat == m_len) m_busy = 0;
    end
    @(negedge clk_dla);
  endtask

  task automatic rand_stim();
    int s, c;
    for (int i = 0; i < NCH; i++) begin
      ch_req_vld[i]          = 1'($urandom_range(0, 1));
      ch_req_dest[i*11 +: 11] = 11'($urandom);
      ch_req_len[i*8 +: 8]   = 8'($urandom_range(0, 5));
      ch_data_vld[i]         = ($urandom_range(0, 9) < 7);
      ch_data[i*64 +: 64]    = {$urandom, $urandom};
    end
    tx_afull    = ($urandom_range(0, 4) == 0);
    grnt_rempty = 1'b1;
    if (!last_ren && $urandom_range(0, 2) == 0) begin
      s = $urandom_range(0, 3);
      for (int k = 0; k < NCH; k++) begin
        c = (s + k) % NCH;
        if (grnt_rempty && (m_cnt[c] - inflight[c]) > 0) send_grant(c, 4'($urandom), 4'($urandom));
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    quiet();
    ch_data_vld = 4'hF;
    while ((m_busy || g_stage_v) && n < 200) begin
      tick();
      n++;
    end
    if (m_busy) fail_now("idle_timeout");
    quiet();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_dla = 1'b1;
    quiet();
    #1;
    chk("rst_busy", 66'(busy), 66'(0));
    chk("rst_tx_wen", 66'(tx_wen), 66'(0));
    @(negedge clk_dla);
    @(negedge clk_dla);
    model_reset();
    rst_dla = 1'b0;
  endtask

  // Monitor: pops expected flits/grants whenever the DUT presents them
  initial begin
    logic [65:0] last;
    gexp_t e;
    last = '0;
    forever begin
      @(posedge clk_dla);
      #1;
      if (rst_dla) begin
        last = '0;
      end else begin
        if (tx_wen) begin
          if (txq.size() == 0) $display("FAIL tx_unexpected act=%h exp=none", tx_wdata);
          if (txq.size() == 0) total_cnt++;
          else chk("tx_flit", tx_wdata, txq.pop_front());
          if (tx_wdata[65:64] == 2'd0 || tx_wdata[65:64] == 2'd3) dut_heads.push_back(int'(tx_wdata[12:11]));
          last = tx_wdata;
        end else begin
          chk("tx_hold", tx_wdata, last);
        end
        if (ch_grant != '0) begin
          if (gq.size() == 0) begin
            total_cnt++;
            $display("FAIL grant_unexpected act=%h exp=none", ch_grant);
          end else begin
            e = gq.pop_front();
            chk("grant", 66'({ch_grant, grant_x, grant_y}), 66'(e));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_dla     = 1'b1;
    ch_req_dest = '0;
    ch_req_len  = '0;
    ch_data     = '0;
    grnt_rdata  = '0;
    quiet();
    model_reset();
    repeat (3) @(negedge clk_dla);
    #1;
    chk("reset_outs", 66'({tx_wen, ch_grant, grant_x, grant_y, err_unexpected_grant, busy, ch_req_rdy, ch_data_rdy}), 66'(0));
    chk("reset_wdata", tx_wdata, 66'(0));
    @(negedge clk_dla);
    rst_dla = 1'b0;

    // Single HEADTAIL on ch1 to dest {3,2,1}
    quiet();
    ch_req_vld[1] = 1'b1;
    ch_req_dest[11 +: 11] = {4'd3, 4'd2, 3'd1};
    ch_req_len[8 +: 8] = 8'd0;
    tick();
    quiet();
    repeat (3) tick();

    // ch0 len=3 with afull high for two cycles mid-body
    ch_req_vld[0] = 1'b1;
    ch_req_len[0 +: 8] = 8'd3;
    ch_req_dest[0 +: 11] = 11'h5A5;
    tick();
    quiet();
    ch_data_vld[0] = 1'b1;
    ch_data[0 +: 64] = 64'hAAAA_0000_AAAA_0001;
    tick();
    tx_afull = 1'b1;
    ch_data[0 +: 64] = 64'hBBBB_0000_BBBB_0002;
    tick();
    tick();
    tx_afull = 1'b0;
    tick();
    ch_data[0 +: 64] = 64'hCCCC_0000_CCCC_0003;
    tick();
    wait_idle();

    // Saturation: all channels request HEADTAIL with no grants
    do_reset();
    dut_heads.delete();
    ch_req_vld = 4'hF;
    ch_req_len = '0;
    for (int i = 0; i < 30; i++) begin
      ch_req_dest = {$urandom, 12'($urandom)};
      tick();
    end
    quiet();
    repeat (3) tick();
    chk("issue_count", 66'(dut_heads.size()), 66'(16));
    for (int k = 0; k < 16 && k < dut_heads.size(); k++) chk("issue_order", 66'(dut_heads[k]), 66'(k % 4));

    // Grant {5,6,2} releases exactly one ch2 slot
    send_grant(2, 4'd5, 4'd6);
    tick();
    quiet();
    repeat (3) tick();
    ch_req_vld = 4'hF;
    repeat (3) tick();
    quiet();
    tick();

    // Drain ch3, then one grant too many
    for (int i = 0; i < 4; i++) begin
      send_grant(3, 4'(i), 4'(i + 1));
      tick();
      quiet();
      tick();
    end
    send_grant(3, 4'd7, 4'd7);
    tick();
    quiet();
    repeat (5) tick();
    chk("err_sticky", 66'(err_unexpected_grant), 66'(1));

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      rand_stim();
      tick();
    end
    wait_idle();
    chk("err_still_set", 66'(err_unexpected_grant), 66'(1));

    // Reset in the middle of a len=5 body
    ch_req_vld[2] = 1'b1;
    ch_req_len[16 +: 8] = 8'd5;
    tick();
    quiet();
    ch_data_vld = 4'b0100;
    tick();
    tick();
    do_reset();
    tick();
    chk("post_rst_err", 66'(err_unexpected_grant), 66'(0));
    ch_req_vld[2] = 1'b1;
    ch_req_len[16 +: 8] = 8'd1;
    ch_req_dest[22 +: 11] = 11'h123;
    tick();
    wait_idle();
    ch_req_vld[3] = 1'b1;
    ch_req_len[24 +: 8] = 8'd0;
    repeat (6) tick();
    quiet();
    repeat (5) tick();

    chk("txq_empty", 66'(txq.size()), 66'(0));
    chk("gq_empty", 66'(gq.size()), 66'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dla_noc_mc_packetizer.md
Name: dla_noc_mc_packetizer

Overview:
DLA-side, multi-channel packetizer for the NoC bridge, in the clk_dla domain. Arbitrates NUM_CH DLA request channels round-robin and serialises each request into HEAD/BODY/TAIL (or HEADTAIL) flits written into the DLA-to-router async FIFO write port. Consumes grant returns from the router-to-DLA grant FIFO read port and tracks per-channel outstanding packets, throttling each channel at MAX_OUT.

Parameters:
NUM_CH, 4, number of DLA channels (1..4); the channel index is the 2-bit dla id.
DATA_W, 64, flit data width; must be >= L_W+2*(X_W+Y_W)+2.
LABEL_W, 2, flit label width. Encoding: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
X_W, 4, destination/source x width.
Y_W, 4, destination/source y width.
L_W, 3, destination local-port width.
LEN_W, 8, body-beat count width.
MAX_OUT, 4, maximum outstanding (ungranted) packets per channel.
SRC_X, 0, this node's x coordinate.
SRC_Y, 0, this node's y coordinate.

Ports:
clk_dla  in  1  DLA clock.
rst_dla  in  1  Asynchronous, active-high reset.
ch_req_vld  in  NUM_CH  Per-channel packet request.
ch_req_rdy  out  NUM_CH  Request accepted (one-cycle pulse).
ch_req_dest  in  NUM_CH*(X_W+Y_W+L_W)  Per-channel destination {x,y,l}, with l in the LSBs.
ch_req_len  in  NUM_CH*LEN_W  Number of body beats; 0 produces a HEADTAIL packet.
ch_data_vld  in  NUM_CH  Body beat available.
ch_data  in  NUM_CH*DATA_W  Body beat data.
ch_data_rdy  out  NUM_CH  Body beat consumed this cycle.
tx_afull  in  1  Write FIFO almost-full.
tx_wen  out  1  Write FIFO write enable.
tx_wdata  out  LABEL_W+DATA_W  Flit, {label, data}.
grnt_rempty  in  1  Grant FIFO empty.
grnt_ren  out  1  Grant FIFO read enable.
grnt_rdata  in  X_W+Y_W+2  Grant {x,y,dla}; dla occupies [1:0].
ch_grant  out  NUM_CH  Per-channel grant pulse.
grant_x  out  X_W  x coordinate of the granting node.
grant_y  out  Y_W  y coordinate of the granting node.
err_unexpected_grant  out  1  Sticky flag: grant received while the channel's count is 0.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer at 0; all outstanding counters 0.
- Eligibility: a channel is eligible when ch_req_vld[i] is high and out_cnt[i] < MAX_OUT.
- IDLE:
  - If any channel is eligible and !tx_afull: select one round-robin, starting after the last winner.
  - Pulse ch_req_rdy[i].
  - Latch the channel, dest and len.
  - Register a HEAD flit, or HEADTAIL if len==0.
  - Increment out_cnt[i].
  - Next state is BODY if len>0, otherwise IDLE.
- Head flit data layout:
  - [L_W-1:0] = l.
  - Then y, then x.
  - Next X_W+Y_W+2 bits = {SRC_X, SRC_Y, 2'(ch)}.
  - Remaining bits are 0.
- BODY:
  - Each cycle with ch_data_vld[ch] and !tx_afull: pulse ch_data_rdy[ch] and register a flit carrying ch_data.
  - Label is BODY, or TAIL on the beat where beat_cnt==len.
  - After TAIL, return to IDLE.
  - Stall while tx_afull is high or data is not valid; no flit is written on a stall.
- Write latency: tx_wen/tx_wdata are registered and appear one cycle after the accept decision. tx_wen is a single-cycle pulse per flit. tx_wdata holds its last value while tx_wen is low.
- Round-robin pointer: updates only on a HEAD/HEADTAIL issue. A channel cannot win twice in a row while another channel is eligible.
- Grant path:
  - grnt_ren = !grnt_rempty (combinational).
  - grnt_rdata is valid the cycle after grnt_ren.
  - The following cycle (2 cycles after ren), registered: ch_grant[dla]=1 and grant_x/grant_y are loaded.
  - dla >= NUM_CH: the grant is ignored and err_unexpected_grant is set.
- Outstanding counters:
  - Simultaneous issue and grant on the same channel leaves the count unchanged.
  - A grant with count 0 keeps the count at 0 and sets err_unexpected_grant.
  - err_unexpected_grant clears only on reset.
- Reset mid-packet aborts the packet: FSM returns to IDLE, counters clear, and no further flits of that packet are written.
- Changing ch_req_* while ch_req_rdy is low is legal. Inputs are sampled only at acceptance.

Test Plan:
- Ch1 request, len=0, dest x=3,y=2,l=1: one tx_wen, label 3, data[10:0]={3,2,1}, head payload {SRC_X,SRC_Y,1}; out_cnt[1]=1.
- Ch0 request, len=3, data A,B,C, tx_afull toggled high for 2 cycles mid-body: flits HEAD,BODY(A),BODY(B),TAIL(C) in order; no tx_wen while afull.
- All 4 channels request continuously, len=0: issue order 0,1,2,3,0,...; each channel stops at 4 outstanding until grants return.
- Grant rdata {x=5,y=6,dla=2} with rempty low for 1 cycle: grnt_ren for 1 cycle; ch_grant[2] pulses 2 cycles later with grant_x=5, grant_y=6; out_cnt[2] decrements.
- Grant for ch3 with out_cnt[3]=0: err_unexpected_grant=1 and stays high; count remains 0.
- rst_dla asserted during BODY of a len=5 packet: busy=0, tx_wen=0, all counters 0 next cycle; the next request starts with a fresh HEAD.
